// File: rtl/ws2812_bit_encoder_pkg.sv
// Shared types and defaults for the WS2812 bit encoder: FSM encoding,
// 50 MHz timing defaults, GRB word width and the captured-bit payload.
package ws2812_bit_encoder_pkg;

  // Encoder FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } enc_state_e;

  // Default WS2812 timing at 50 MHz
  localparam int unsigned T0H_CYC_DEF = 20;    // 0.40 us
  localparam int unsigned T1H_CYC_DEF = 40;    // 0.80 us
  localparam int unsigned BIT_CYC_DEF = 63;    // 1.26 us
  localparam int unsigned RST_CYC_DEF = 2600;  // 52 us

  // One GRB pixel word, shared with the upstream shift register
  localparam int unsigned GRB_W = 24;

  // Bit captured on handshake: its value and whether it closes the frame
  typedef struct packed {
    logic data;
    logic last;
  } led_bit_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold 0 .. max(bit_cyc, rst_cyc)-1
  function automatic int unsigned cnt_width(input int unsigned bit_cyc,
                                            input int unsigned rst_cyc);
    int unsigned m;
    m = max_u(bit_cyc, rst_cyc);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// WS2812 single-wire bit encoder. Takes one colour bit per valid/ready
// handshake and emits a fixed-period pulse whose high time encodes the bit.
// After the frame's last bit the line is held low for the latch period and
// latch_done pulses once. A bit accepted on the final cycle of the previous
// bit continues the waveform without a gap.
module ws2812_bit_encoder
  import ws2812_bit_encoder_pkg::*;
#(
  parameter int unsigned T0H_CYC = T0H_CYC_DEF,
  parameter int unsigned T1H_CYC = T1H_CYC_DEF,
  parameter int unsigned BIT_CYC = BIT_CYC_DEF,
  parameter int unsigned RST_CYC = RST_CYC_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic bit_last,
  output logic bit_ready,
  output logic dout,
  output logic busy,
  output logic latch_done
);

  localparam int unsigned CNT_W = cnt_width(BIT_CYC, RST_CYC);

  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] LAT_END = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] T0H_LIM = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] T1H_LIM = CNT_W'(T1H_CYC);

  // Reject timing sets that cannot form a valid WS2812 waveform
  if (!((T0H_CYC > 0) && (T0H_CYC < T1H_CYC) && (T1H_CYC < BIT_CYC) &&
        (RST_CYC >= 2))) begin : g_bad_timing
    $error("ws2812_bit_encoder: need 0 < T0H_CYC < T1H_CYC < BIT_CYC and RST_CYC >= 2");
  end

  enc_state_e       state;
  enc_state_e       state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  led_bit_t         cur;
  led_bit_t         cur_n;
  logic             accept;

  logic             dout_n;
  logic             busy_n;
  logic             bit_ready_n;
  logic             latch_done_n;

  // Next-state, counter and next-output decode
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    cur_n        = cur;
    accept       = bit_valid && bit_ready;
    dout_n       = 1'b0;
    busy_n       = 1'b0;
    bit_ready_n  = 1'b0;
    latch_done_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n    = SEND;
          cnt_n      = '0;
          cur_n.data = bit_in;
          cur_n.last = bit_last;
        end
      end

      SEND: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          if (cur.last) begin
            state_n = LATCH;
          end else if (accept) begin
            // Next bit starts immediately: no idle cycle on the line
            cur_n.data = bit_in;
            cur_n.last = bit_last;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      LATCH: begin
        if (cnt == LAT_END) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Outputs are decoded from the next state so the flops line up with it
    dout_n       = (state_n == SEND) &&
                   (cnt_n < (cur_n.data ? T1H_LIM : T0H_LIM));
    busy_n       = (state_n != IDLE);
    bit_ready_n  = (state_n == IDLE) ||
                   ((state_n == SEND) && (cnt_n == BIT_END) && !cur_n.last);
    latch_done_n = (state_n == LATCH) && (cnt_n == LAT_END);
  end

  // FSM state, bit-period counter and captured bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      cur   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cur   <= cur_n;
    end
  end

  // Registered outputs; the line comes straight from a flop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout       <= 1'b0;
      busy       <= 1'b0;
      bit_ready  <= 1'b1;
      latch_done <= 1'b0;
    end else begin
      dout       <= dout_n;
      busy       <= busy_n;
      bit_ready  <= bit_ready_n;
      latch_done <= latch_done_n;
    end
  end

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Bench for ws2812_bit_encoder with short simulation timing. Streams of bits
// are described as (value, last, offer gap) beats; a timeline model derives
// accept cycles and the per-cycle {dout,busy,bit_ready,latch_done} waveform.
module tb_ws2812_bit_encoder;
  import ws2812_bit_encoder_pkg::*;

  localparam int T0H    = 2;
  localparam int T1H    = 4;
  localparam int BITC   = 6;
  localparam int RSTC   = 10;
  localparam int MAXC   = 16384;
  localparam int BUDGET = 200;

  typedef struct {
    logic b;
    logic last;
    int   gap;  // offer cycle = previous accept + BITC + gap
  } beat_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_last = 1'b0;
  logic bit_ready;
  logic dout;
  logic busy;
  logic latch_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  beat_t beats[$];
  int pred_offer[$];
  int pred_acc[$];
  int act_acc[$];
  int win_lo;
  int win_hi;
  logic [3:0] exp_vec[MAXC];
  logic [3:0] act_vec[MAXC];

  ws2812_bit_encoder #(
    .T0H_CYC(T0H),
    .T1H_CYC(T1H),
    .BIT_CYC(BITC),
    .RST_CYC(RSTC)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bit_in(bit_in),
    .bit_valid(bit_valid),
    .bit_last(bit_last),
    .bit_ready(bit_ready),
    .dout(dout),
    .busy(busy),
    .latch_done(latch_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record outputs mid-cycle, indexed by cycle number
  always @(negedge clk) begin
    if (cyc < MAXC) act_vec[cyc] <= {dout, busy, bit_ready, latch_done};
  end

  initial begin
    #(10 * MAXC);
    $display("FAIL watchdog cyc=%0d limit=%0d", cyc, MAXC);
    $fatal(1, "watchdog expired");
  end

  task automatic add_beat(input logic b, input logic last, input int gap);
    beat_t x;
    x.b = b;
    x.last = last;
    x.gap = gap;
    beats.push_back(x);
  endtask

  // Timeline model: when each bit is taken and what the line looks like
  task automatic build_model(input int start);
    int ready_from;
    int offer;
    int a;
    int hi_t;
    pred_offer.delete();
    pred_acc.delete();
    ready_from = start;
    foreach (beats[i]) begin
      offer = (i == 0) ? start : pred_acc[i-1] + BITC + beats[i].gap;
      a = (offer > ready_from) ? offer : ready_from;
      pred_offer.push_back(offer);
      pred_acc.push_back(a);
      ready_from = a + BITC + (beats[i].last ? RSTC + 1 : 0);
    end
    win_lo = start;
    win_hi = ready_from + 3;
    for (int c = win_lo; c <= win_hi; c++) exp_vec[c] = 4'b0010;
    foreach (beats[i]) begin
      a = pred_acc[i];
      hi_t = beats[i].b ? T1H : T0H;
      for (int t = 1; t <= BITC; t++)
        exp_vec[a+t] = {(t <= hi_t), 1'b1, (t == BITC && !beats[i].last), 1'b0};
      if (beats[i].last)
        for (int t = BITC + 1; t <= BITC + RSTC; t++)
          exp_vec[a+t] = {1'b0, 1'b1, 1'b0, (t == BITC + RSTC)};
    end
  endtask

  // Drive the beat list: offer each bit at its cycle, hold until taken
  task automatic run_stream();
    int start;
    int budget;
    bit got;
    start = cyc + 2;
    build_model(start);
    act_acc.delete();
    foreach (beats[i]) begin
      while (cyc < pred_offer[i]) begin @(posedge clk); #1; end
      bit_valid = 1'b1;
      bit_in = beats[i].b;
      bit_last = beats[i].last;
      got = 1'b0;
      budget = 0;
      while (!got && budget < BUDGET) begin
        @(negedge clk);
        if (bit_ready) begin act_acc.push_back(cyc); got = 1'b1; end
        @(posedge clk); #1;
        budget++;
      end
      bit_valid = 1'b0;
      bit_in = 1'($urandom);
      bit_last = 1'($urandom);
      if (!got) begin
        checks++; failures++;
        $display("FAIL accept_timeout beat=%0d got=none want=cycle %0d", i, pred_acc[i]);
      end
    end
    while (cyc <= win_hi) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dout, busy, latch_done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_hold {dout,busy,ldone} got=%b want=000", {dout, busy, latch_done});
    end
    rstn = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if ({dout, busy, bit_ready, latch_done} !== 4'b0010) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d {dout,busy,ready,ldone} got=%b want=0010",
                 cyc, {dout, busy, bit_ready, latch_done});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_bit();
    int k;
    logic [3:0] v;
    beats.delete();
    add_beat(1'b1, 1'b1, 0);
    run_stream();
    k = pred_offer[0];
    checks++;
    if (act_acc.size() != 1 || act_acc[0] != k) begin
      failures++;
      $display("FAIL single_accept got=%0d want=%0d", (act_acc.size() > 0) ? act_acc[0] : -1, k);
    end
    for (int t = 1; t <= 16; t++) begin
      v = act_vec[k+t];
      checks++;
      if (v[3] !== (t <= 4) || v[2] !== 1'b1 || v[0] !== (t == 16)) begin
        failures++;
        $display("FAIL single_wave k+%0d {dout,busy,ready,ldone} got=%b want dout=%0d busy=1 ldone=%0d",
                 t, v, (t <= 4), (t == 16));
      end
    end
    v = act_vec[k+17];
    checks++;
    if (v !== 4'b0010) begin
      failures++;
      $display("FAIL single_after_latch {dout,busy,ready,ldone} got=%b want=0010", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [GRB_W-1:0] w;
    int nbusy;
    int nld;
    w = 24'hE15F11;
    beats.delete();
    for (int i = 0; i < GRB_W; i++) add_beat(w[GRB_W-1-i], (i == GRB_W - 1), 1 - BITC);
    run_stream();
    for (int c = win_lo; c <= win_hi; c++) begin
      checks++;
      if (act_vec[c] !== exp_vec[c]) begin
        failures++;
        $display("FAIL word_wave cyc=%0d {dout,busy,ready,ldone} got=%b want=%b", c, act_vec[c], exp_vec[c]);
      end
    end
    for (int i = 0; i < beats.size(); i++) begin
      checks++;
      if (i >= act_acc.size() || act_acc[i] != pred_acc[i]) begin
        failures++;
        $display("FAIL word_accept beat=%0d got=%0d want=%0d", i,
                 (i < act_acc.size()) ? act_acc[i] : -1, pred_acc[i]);
      end
    end
    nbusy = 0;
    nld = 0;
    for (int c = win_lo; c <= win_hi; c++) begin
      nbusy += int'(act_vec[c][2]);
      nld += int'(act_vec[c][0]);
    end
    checks++;
    if (nbusy != GRB_W * BITC + RSTC || nld != 1) begin
      failures++;
      $display("FAIL word_span busy_cycles=%0d latch_pulses=%0d want %0d and 1", nbusy, nld, GRB_W * BITC + RSTC);
    end
  endtask

  task automatic test_gap();
    int a;
    beats.delete();
    for (int i = 0; i < 8; i++)
      add_beat(1'($urandom), (i == 7), (i == 4) ? 5 : 1 - BITC);
    run_stream();
    for (int c = win_lo; c <= win_hi; c++) begin
      checks++;
      if (act_vec[c] !== exp_vec[c]) begin
        failures++;
        $display("FAIL gap_wave cyc=%0d {dout,busy,ready,ldone} got=%b want=%b", c, act_vec[c], exp_vec[c]);
      end
    end
    a = pred_offer[4];
    checks++;
    if (act_acc.size() < 5 || act_acc[4] != a) begin
      failures++;
      $display("FAIL gap_accept got=%0d want=%0d", (act_acc.size() > 4) ? act_acc[4] : -1, a);
    end
    checks++;
    if (act_vec[a][3:2] !== 2'b00 || act_vec[a+1][3] !== 1'b1 || act_vec[a-1][2] !== 1'b0) begin
      failures++;
      $display("FAIL gap_edge acc=%b acc+1=%b acc-1=%b want dout,busy=00 then dout=1, idle before",
               act_vec[a], act_vec[a+1], act_vec[a-1]);
    end
  endtask

  task automatic test_reset_mid_send();
    bit_valid = 1'b1;
    bit_in = 1'b1;
    bit_last = 1'b0;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    @(posedge clk); #1;
    #2;
    checks++;
    if (dout !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre dout got=%b want=1", dout);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({dout, busy, latch_done} !== 3'b000) begin
      failures++;
      $display("FAIL midrst_async {dout,busy,ldone} got=%b want=000", {dout, busy, latch_done});
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({dout, busy, bit_ready, latch_done} !== 4'b0010) begin
      failures++;
      $display("FAIL midrst_idle {dout,busy,ready,ldone} got=%b want=0010", {dout, busy, bit_ready, latch_done});
    end
    @(posedge clk); #1;
    beats.delete();
    add_beat(1'b0, 1'b1, 0);
    run_stream();
    for (int c = win_lo; c <= win_hi; c++) begin
      checks++;
      if (act_vec[c] !== exp_vec[c]) begin
        failures++;
        $display("FAIL midrst_wave cyc=%0d {dout,busy,ready,ldone} got=%b want=%b", c, act_vec[c], exp_vec[c]);
      end
    end
  endtask

  task automatic test_latch_valid();
    int a;
    beats.delete();
    add_beat(1'($urandom), 1'b1, 0);
    add_beat(1'($urandom), 1'b1, 1 - BITC);
    run_stream();
    a = pred_acc[0];
    for (int t = 1; t <= BITC + RSTC; t++) begin
      checks++;
      if (act_vec[a+t][1] !== 1'b0) begin
        failures++;
        $display("FAIL latch_ready k+%0d got=%b want=0", t, act_vec[a+t][1]);
      end
    end
    checks++;
    if (act_acc.size() != 2 || act_acc[1] != a + BITC + RSTC + 1) begin
      failures++;
      $display("FAIL latch_accept got=%0d want=%0d",
               (act_acc.size() > 1) ? act_acc[1] : -1, a + BITC + RSTC + 1);
    end
    for (int c = win_lo; c <= win_hi; c++) begin
      checks++;
      if (act_vec[c] !== exp_vec[c]) begin
        failures++;
        $display("FAIL latch_wave cyc=%0d {dout,busy,ready,ldone} got=%b want=%b", c, act_vec[c], exp_vec[c]);
      end
    end
  endtask

  task automatic test_random();
    int n;
    beats.delete();
    for (int f = 0; f < 4; f++) begin
      n = int'($urandom_range(12, 1));
      for (int i = 0; i < n; i++)
        add_beat(1'($urandom), (i == n - 1), int'($urandom_range(11, 0)) - 5);
    end
    run_stream();
    for (int c = win_lo; c <= win_hi; c++) begin
      checks++;
      if (act_vec[c] !== exp_vec[c]) begin
        failures++;
        $display("FAIL rand_wave cyc=%0d {dout,busy,ready,ldone} got=%b want=%b", c, act_vec[c], exp_vec[c]);
      end
    end
    for (int i = 0; i < beats.size(); i++) begin
      checks++;
      if (i >= act_acc.size() || act_acc[i] != pred_acc[i]) begin
        failures++;
        $display("FAIL rand_accept beat=%0d got=%0d want=%0d", i,
                 (i < act_acc.size()) ? act_acc[i] : -1, pred_acc[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_back_to_back();
    test_gap();
    test_reset_mid_send();
    test_latch_valid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
